axis_frame_gate: RTL

- Frame-granular controller that sits in front of the fps_counter AXI stream input and decides per frame whether a frame is forwarded or discarded.
- Modes: continuous pass, pass exactly N frames, and decimate (keep 1 of K).
- Frame integrity is always preserved. Pass/drop decisions are taken only on a start-of-frame beat (tuser=1); a frame is never cut mid-way.
- Provides status counters for software and bench correlation.

---
 rtl/axis_frame_gate_pkg.sv | 26 ++
 rtl/axis_frame_gate.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/axis_frame_gate_pkg.sv
// axis_frame_gate_pkg
//   Shared encodings for the frame gate:
//   - gate_mode_e  : run modes selected by i_mode
//   - gate_state_e : FSM states of the gate
//   - normalize_mode() folds the reserved mode onto pass-all.
package axis_frame_gate_pkg;

    typedef enum logic [1:0] {
        MODE_PASS_ALL = 2'd0,
        MODE_PASS_N   = 2'd1,
        MODE_DECIMATE = 2'd2,
        MODE_RESERVED = 2'd3
    } gate_mode_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        PASS     = 2'd2,
        DROP     = 2'd3
    } gate_state_e;

    function automatic gate_mode_e normalize_mode(input logic [1:0] raw);
        return (raw == MODE_RESERVED) ? MODE_PASS_ALL : gate_mode_e'(raw);
    endfunction

endpackage

// File: rtl/axis_frame_gate.sv
// axis_frame_gate
//   Frame-granular gate in front of an AXI stream sink. Each frame (SOF
//   marked by tuser) is either forwarded whole or discarded whole.
//   Ports:
//     i_axi_clk, i_axi_rst          clock, async active-high reset
//     i_start / i_abort             run control pulses
//     i_mode / i_count              run mode and its N or K argument
//     o_busy / o_done               armed flag, end-of-run pulse
//     o_frames_passed / _dropped    saturating status counters
//     i_axis_in_* / o_axis_in_tready    input stream
//     o_axis_out_* / i_axis_out_tready  output stream (zero latency)
module axis_frame_gate
    import axis_frame_gate_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = 8,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                       i_axi_clk,
    input  logic                       i_axi_rst,
    input  logic                       i_start,
    input  logic                       i_abort,
    input  logic [1:0]                 i_mode,
    input  logic [COUNT_WIDTH-1:0]     i_count,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [COUNT_WIDTH-1:0]     o_frames_passed,
    output logic [COUNT_WIDTH-1:0]     o_frames_dropped,
    input  logic                       i_axis_in_tuser,
    input  logic                       i_axis_in_tvalid,
    input  logic                       i_axis_in_tlast,
    input  logic [AXIS_DATA_WIDTH-1:0] i_axis_in_tdata,
    output logic                       o_axis_in_tready,
    output logic                       o_axis_out_tuser,
    output logic                       o_axis_out_tvalid,
    output logic                       o_axis_out_tlast,
    output logic [AXIS_DATA_WIDTH-1:0] o_axis_out_tdata,
    input  logic                       i_axis_out_tready
);

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    gate_state_e            state_q, state_d;
    gate_mode_e             mode_q, mode_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [COUNT_WIDTH-1:0] phase_q, phase_d;
    logic [COUNT_WIDTH-1:0] passed_q, passed_d;
    logic [COUNT_WIDTH-1:0] dropped_q, dropped_d;
    logic                   abort_pend_q, abort_pend_d;
    logic                   done_q, done_d;

    logic fwd;            // current beat belongs to the forward phase
    logic sof_beat;       // SOF presented this cycle (not necessarily accepted)
    logic take_decision;  // SOF presented in an armed state
    logic end_run;        // this SOF closes the run
    logic pass_frame;     // this SOF starts a forwarded frame
    logic accept;
    logic decimate_all;   // K of 0 or 1 degenerates to pass-all

    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        count_d       = count_q;
        phase_d       = phase_q;
        passed_d      = passed_q;
        dropped_d     = dropped_q;
        abort_pend_d  = abort_pend_q;
        done_d        = 1'b0;
        take_decision = 1'b0;
        fwd           = (state_q == PASS);

        // Decision inputs come from registered state and tvalid/tuser only,
        // never from tready, so there is no combinational loop via accept.
        sof_beat     = i_axis_in_tvalid & i_axis_in_tuser;
        decimate_all = (count_q <= COUNT_WIDTH'(1));
        end_run      = abort_pend_q ||
                       ((mode_q == MODE_PASS_N) && (passed_q >= count_q));
        pass_frame   = (mode_q != MODE_DECIMATE) || decimate_all ||
                       (phase_q == '0);

        unique case (state_q)
            IDLE: begin
                if (i_start && !i_abort) begin
                    state_d      = WAIT_SOF;
                    mode_d       = normalize_mode(i_mode);
                    count_d      = i_count;
                    phase_d      = '0;
                    passed_d     = '0;
                    dropped_d    = '0;
                    abort_pend_d = 1'b0;
                end
            end
            WAIT_SOF: begin
                if (i_abort) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    take_decision = sof_beat;
                end
            end
            PASS, DROP: begin
                if (i_abort) abort_pend_d = 1'b1;
                take_decision = sof_beat;
            end
        endcase

        // The SOF beat itself already follows the new frame's decision.
        if (take_decision) fwd = !end_run && pass_frame;

        o_axis_in_tready = fwd ? i_axis_out_tready : 1'b1;
        accept           = i_axis_in_tvalid & o_axis_in_tready;

        if (take_decision && accept) begin
            if (end_run) begin
                state_d      = IDLE;
                done_d       = 1'b1;
                abort_pend_d = 1'b0;
            end else if (pass_frame) begin
                state_d  = PASS;
                passed_d = sat_inc(passed_q);
            end else begin
                state_d   = DROP;
                dropped_d = sat_inc(dropped_q);
            end
            if (mode_q == MODE_DECIMATE && !decimate_all) begin
                phase_d = (phase_q == count_q - 1'b1) ? '0 : phase_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge i_axi_clk or posedge i_axi_rst) begin
        if (i_axi_rst) begin
            state_q      <= IDLE;
            mode_q       <= MODE_PASS_ALL;
            count_q      <= '0;
            phase_q      <= '0;
            passed_q     <= '0;
            dropped_q    <= '0;
            abort_pend_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            count_q      <= count_d;
            phase_q      <= phase_d;
            passed_q     <= passed_d;
            dropped_q    <= dropped_d;
            abort_pend_q <= abort_pend_d;
            done_q       <= done_d;
        end
    end

    assign o_axis_out_tvalid = fwd & i_axis_in_tvalid;
    assign o_axis_out_tuser  = i_axis_in_tuser;
    assign o_axis_out_tlast  = i_axis_in_tlast;
    assign o_axis_out_tdata  = i_axis_in_tdata;

    assign o_busy           = (state_q != IDLE);
    assign o_done           = done_q;
    assign o_frames_passed  = passed_q;
    assign o_frames_dropped = dropped_q;

endmodule
